// File: rtl/nios2_cpu_div_cell.sv
// Multi-cycle radix-2 restoring divider with fixed latency (start edge + DATA_W + 2).
// Signed operation is compiled in only when NIOS2_DIV_CELL_SIGNED_EN is defined.
module nios2_cpu_div_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              M_div_start,
  input  logic [DATA_W-1:0] M_div_src1,
  input  logic [DATA_W-1:0] M_div_src2,
  input  logic              M_div_signed,
  output logic              M_div_busy,
  output logic              M_div_done,
  output logic [DATA_W-1:0] M_div_quotient,
  output logic [DATA_W-1:0] M_div_remainder,
  output logic              M_div_by_zero
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_a_neg;
  logic              r_b_neg;
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] r_d;
  logic [DATA_W:0]   r_prem;
  logic              r_busy;
  logic              r_done;
  logic              r_by_zero;
  logic [DATA_W-1:0] r_quot;
  logic [DATA_W-1:0] r_rmd;

  logic              w_src1_neg;
  logic              w_src2_neg;
  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_diff;
  logic              w_fits;
  logic [DATA_W-1:0] w_rem_mag;
  logic              w_unused_prem_msb;

`ifdef NIOS2_DIV_CELL_SIGNED_EN
  assign w_src1_neg = M_div_signed & M_div_src1[DATA_W-1];
  assign w_src2_neg = M_div_signed & M_div_src2[DATA_W-1];
`else
  logic w_unused_signed;
  assign w_unused_signed = M_div_signed;
  assign w_src1_neg      = 1'b0;
  assign w_src2_neg      = 1'b0;
`endif

  // Partial remainder stays below the divisor, so only its low DATA_W bits feed the next shift.
  assign w_shift           = {r_prem[DATA_W-1:0], r_q[DATA_W-1]};
  assign w_diff            = w_shift - {1'b0, r_d};
  assign w_fits            = ~w_diff[DATA_W];
  assign w_rem_mag         = r_prem[DATA_W-1:0];
  assign w_unused_prem_msb = r_prem[DATA_W];

  // NOTE: all state below is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_a_neg   <= 1'b0;
      r_b_neg   <= 1'b0;
      r_q       <= '0;
      r_d       <= '0;
      r_prem    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_by_zero <= 1'b0;
      r_quot    <= '0;
      r_rmd     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (M_div_start) begin
            r_state   <= S_RUN;
            r_cnt     <= '0;
            r_a       <= M_div_src1;
            r_b       <= M_div_src2;
            r_a_neg   <= w_src1_neg;
            r_b_neg   <= w_src2_neg;
            r_busy    <= 1'b1;
            r_by_zero <= 1'b0;
          end
        end
        S_RUN: begin
          if (r_cnt == '0) begin
            // First RUN cycle converts operands to magnitudes, off the start path.
            r_q    <= r_a_neg ? -r_a : r_a;
            r_d    <= r_b_neg ? -r_b : r_b;
            r_prem <= '0;
            r_cnt  <= r_cnt + 1'b1;
          end else begin
            r_prem <= w_fits ? w_diff : w_shift;
            r_q    <= {r_q[DATA_W-2:0], w_fits};
            if (r_cnt == CNT_W'(DATA_W)) begin
              r_state <= S_FIX;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_FIX: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          if (r_d == '0) begin
            r_quot    <= '1;
            r_rmd     <= r_a;
            r_by_zero <= 1'b1;
          end else begin
            r_quot <= (r_a_neg ^ r_b_neg) ? -r_q : r_q;
            r_rmd  <= r_a_neg ? -w_rem_mag : w_rem_mag;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign M_div_busy      = r_busy;
  assign M_div_done      = r_done;
  assign M_div_quotient  = r_quot;
  assign M_div_remainder = r_rmd;
  assign M_div_by_zero   = r_by_zero;

endmodule

// File: tb/tb_nios2_cpu_div_cell.sv
// Directed bench for nios2_cpu_div_cell (DATA_W=32); expectations follow NIOS2_DIV_CELL_SIGNED_EN.
module tb_nios2_cpu_div_cell;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         sgn = 1'b0;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic         busy, done, by_zero;
  logic [W-1:0] quot, rmd;

  int n_tests = 0;
  int n_fail  = 0;

  nios2_cpu_div_cell #(.DATA_W(W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .M_div_start    (start),
    .M_div_src1     (src1),
    .M_div_src2     (src2),
    .M_div_signed   (sgn),
    .M_div_busy     (busy),
    .M_div_done     (done),
    .M_div_quotient (quot),
    .M_div_remainder(rmd),
    .M_div_by_zero  (by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one divide and checks latency, busy window, results and the done pulse width.
  // With inject set, extra starts are pulsed at cycles 5, 20 and in the DONE cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ez, input logic inject);
    int lat = -1;
    int busy_cnt = 0;
    logic busy_at_done = 1'b0;
    src1  = a;
    src2  = b;
    sgn   = s;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < 60 && lat < 0; n++) begin
      @(negedge clk);
      if (n == 0) check({tag, "/bz_clr"}, 32'(by_zero), 32'(0));
      if (inject && (n == 5 || n == 20)) begin
        src1  = ~a;
        src2  = b + 32'd3;
        sgn   = ~s;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = n;
        busy_at_done = busy;
      end else if (busy) begin
        busy_cnt++;
      end
    end
    check({tag, "/latency"}, 32'(lat), 32'(W + 2));
    check({tag, "/busy_cycles"}, 32'(busy_cnt), 32'(W + 2));
    check({tag, "/busy_in_done"}, 32'(busy_at_done), 32'(1));
    check({tag, "/quotient"}, quot, eq);
    check({tag, "/remainder"}, rmd, er);
    check({tag, "/by_zero"}, 32'(by_zero), 32'(ez));
    if (inject) begin
      src1  = 32'd77;
      src2  = 32'd5;
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, "/done_drop"}, 32'(done), 32'(0));
    check({tag, "/busy_drop"}, 32'(busy), 32'(0));
    if (inject) begin
      repeat (3) @(negedge clk);
      check({tag, "/q_hold"}, quot, eq);
      check({tag, "/r_hold"}, rmd, er);
      check({tag, "/idle"}, 32'(busy), 32'(0));
    end
  endtask

  initial begin
    int done_seen;
    repeat (2) @(negedge clk);
    check("rst/busy", 32'(busy), 32'(0));
    check("rst/done", 32'(done), 32'(0));
    check("rst/quot", quot, 32'(0));
    check("rst/rmd", rmd, 32'(0));
    check("rst/bz", 32'(by_zero), 32'(0));

    // Start requested in the same cycle reset is released.
    reset_n = 1'b1;
    run_op("100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0);
    run_op("max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    run_op("5/0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
    run_op("1000/10", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 1'b0);
`ifdef NIOS2_DIV_CELL_SIGNED_EN
    run_op("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("smin/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    run_op("s100/-7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0);
`else
    run_op("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0);
    run_op("smin/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
    run_op("s100/-7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'd0, 32'd100, 1'b0, 1'b0);
`endif
    run_op("s-5/0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0);
    run_op("inject", 32'd1234567, 32'd89, 1'b0, 32'd13871, 32'd48, 1'b0, 1'b1);

    // Abort mid-operation with reset.
    src1  = 32'd1000;
    src2  = 32'd3;
    sgn   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort/busy", 32'(busy), 32'(0));
    check("abort/done", 32'(done), 32'(0));
    check("abort/quot", quot, 32'(0));
    check("abort/rmd", rmd, 32'(0));
    check("abort/bz", 32'(by_zero), 32'(0));
    done_seen = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort/no_done", 32'(done_seen), 32'(0));
    run_op("9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nios2_cpu_div_cell.md
NIOS2_CPU_DIV_CELL -- requirements
Module: nios2_cpu_div_cell

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand/result width; legal values are even numbers from 8 to 32.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port M_div_start, input, 1 bit: request a divide; sampled only in IDLE.
REQ-005 SHALL have port M_div_src1, input, DATA_W bits: dividend, captured on the accepted start.
REQ-006 SHALL have port M_div_src2, input, DATA_W bits: divisor, captured on the accepted start.
REQ-007 SHALL have port M_div_signed, input, 1 bit: signed-operation request, captured on the accepted start.
REQ-008 SHALL have port M_div_busy, output, 1 bit: operation in progress.
REQ-009 SHALL have port M_div_done, output, 1 bit: one-cycle pulse marking valid results.
REQ-010 SHALL have port M_div_quotient, output, DATA_W bits: quotient.
REQ-011 SHALL have port M_div_remainder, output, DATA_W bits: remainder.
REQ-012 SHALL have port M_div_by_zero, output, 1 bit: the last operation had divisor 0.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIX, DONE: IDLE->RUN on start; RUN->FIX after DATA_W iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-014 SHALL use radix-2 restoring division in RUN, one quotient bit per cycle, MSB first, with a DATA_W+1-bit partial remainder.
REQ-015 SHALL have a fixed latency: start accepted at edge k -> M_div_done high for exactly the cycle after edge k+DATA_W+2, independent of operands.
REQ-016 SHALL assert M_div_busy from edge k through the end of the DONE cycle, and SHALL drive it low in IDLE.
REQ-017 SHALL ignore M_div_start while busy, including in the DONE cycle, with no queuing.
REQ-018 SHALL hold M_div_quotient, M_div_remainder and M_div_by_zero stable from the DONE cycle until the next accepted start.
REQ-019 SHALL produce, on a zero divisor: quotient all ones, remainder = dividend, M_div_by_zero=1, with the same latency.
REQ-020 SHALL clear M_div_by_zero on the next accepted start.
REQ-021 SHALL make FIX a pass-through cycle when the signed path is disabled or not requested.
REQ-022 SHALL meet quotient*divisor + remainder == dividend (mod 2^DATA_W) for every nonzero divisor.

Reset
REQ-023 SHALL, on reset_n low, force IDLE immediately and clear M_div_busy, M_div_done, M_div_quotient, M_div_remainder and M_div_by_zero to 0.
REQ-024 SHALL, on reset mid-operation, abort the operation with no done pulse.
REQ-025 SHALL accept the first start at the first rising edge after reset_n deasserts.

Configuration
REQ-026 SHALL use the macro NIOS2_DIV_CELL_SIGNED_EN to compile in signed support.
REQ-027 SHALL, when NIOS2_DIV_CELL_SIGNED_EN is defined and M_div_signed=1: divide operand magnitudes; negate the quotient in FIX if the operand signs differ; give the remainder the dividend's sign.
REQ-028 SHALL, when NIOS2_DIV_CELL_SIGNED_EN is defined, return quotient = most negative value and remainder 0 for most negative / -1.
REQ-029 SHALL, when NIOS2_DIV_CELL_SIGNED_EN is defined, return quotient all ones and remainder = dividend for a signed divide by zero.
REQ-030 SHALL, when NIOS2_DIV_CELL_SIGNED_EN is not defined, ignore M_div_signed, perform unsigned division only, and keep the same latency.

Verification
REQ-031 SHALL cover: DATA_W=32, 100/7 -> quotient 14, remainder 2, done exactly 34 cycles after the start edge, busy high for 34 cycles.
REQ-032 SHALL cover: 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0; 5/0 -> quotient 0xFFFFFFFF, remainder 5, M_div_by_zero=1.
REQ-033 SHALL cover: signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF with the macro; without it -> quotient 0x7FFFFFFC, remainder 1.
REQ-034 SHALL cover, with the macro: signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-035 SHALL cover: a start pulsed at cycles 5 and 20 of an operation is ignored, and the results match the first operands only.
REQ-036 SHALL cover: reset_n low at iteration 10 -> outputs 0 and no done pulse; a new 9/3 start after reset -> quotient 3, remainder 0.
